// File: rtl/serial_eq_pkg.sv
// Shared state encoding for the bit-serial word equality comparator.
package serial_eq_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
endpackage

// File: rtl/serial_word_equality_onebit.sv
// One-bit XNOR equality cell: eq_o is high when both inputs match.
module oneBitEquality (
  input  logic a_i,
  input  logic b_i,
  output logic eq_o
);
  assign eq_o = ~(a_i ^ b_i);
endmodule

// File: rtl/serial_word_equality.sv
// Bit-serial WIDTH-bit equality comparator: checks LSB first through a single
// one-bit XNOR cell and stops at the first differing bit.
module serial_word_equality
  import serial_eq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IDX_W-1:0] diff_idx
);

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_COMPARE = ST_COMPARE,
    S_DONE    = ST_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             equal_q, equal_d;
  logic [IDX_W-1:0] diff_idx_q, diff_idx_d;
  logic             eq_bit;

  oneBitEquality u_eq_cell (
    .a_i  (sa_q[0]),
    .b_i  (sb_q[0]),
    .eq_o (eq_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      idx_q      <= '0;
      equal_q    <= 1'b0;
      diff_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      idx_q      <= idx_d;
      equal_q    <= equal_d;
      diff_idx_q <= diff_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    idx_d      = idx_q;
    equal_d    = equal_q;
    diff_idx_d = diff_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d       = a;
          sb_d       = b;
          idx_d      = '0;
          equal_d    = 1'b0;
          diff_idx_d = '0;
          state_d    = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!eq_bit) begin
          equal_d    = 1'b0;
          diff_idx_d = idx_q;
          state_d    = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          equal_d    = 1'b1;
          diff_idx_d = '0;
          state_d    = S_DONE;
        end else begin
          // Counter cannot wrap: the branch above always exits at the last bit.
          sa_d  = {1'b0, sa_q[WIDTH-1:1]};
          sb_d  = {1'b0, sb_q[WIDTH-1:1]};
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_COMPARE);
  assign done     = (state_q == S_DONE);
  assign equal    = equal_q;
  assign diff_idx = diff_idx_q;

endmodule

// File: tb/tb_serial_word_equality.sv
// Randomized and directed bench for serial_word_equality (WIDTH=8) against a
// word-level reference model.
module tb_serial_word_equality;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, equal;
  logic [2:0]   diff_idx;

  int n_cmp = 0;
  int n_err = 0;

  serial_word_equality #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .equal(equal), .diff_idx(diff_idx)
  );

  always #5 clk = ~clk;

  // Reference: word-level verdict from a XOR b.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int k, output logic eq_m, output logic [2:0] idx_m);
    logic [W-1:0] x;
    x = av ^ bv;
    eq_m = (x == 0);
    idx_m = 3'd0;
    k = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) begin
        idx_m = 3'(i);
        k = i + 1;
      end
    end
  endtask

  task automatic do_run(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit hold, input bit chg,
                        output int lat, output int bcnt, output int dcnt,
                        output logic eq_o, output logic [2:0] idx_o,
                        output bit idle_ok, output bit tmo);
    lat = -1; bcnt = 0; dcnt = 0; eq_o = 1'b0; idx_o = 3'd0;
    idle_ok = 1'b0; tmo = 1'b1;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int n = 0; n < 2 * W + 4; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (chg && n == 1) a = '0;
      if (lat >= 0 && n == lat + 1) begin
        idle_ok = !busy && !done;
        tmo = 1'b0;
        break;
      end
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat < 0) begin
          lat = n; eq_o = equal; idx_o = diff_idx;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input bit hold, input bit chg);
    int k, lat, bcnt, dcnt;
    logic eq_m, eq_o;
    logic [2:0] idx_m, idx_o;
    bit idle_ok, tmo;
    model(av, bv, k, eq_m, idx_m);
    do_run(av, bv, hold, chg, lat, bcnt, dcnt, eq_o, idx_o, idle_ok, tmo);
    n_cmp++;
    if (tmo) begin
      n_err++;
      $display("FAIL %s timeout: a=%h b=%h no done within budget", name, av, bv);
    end
    n_cmp++;
    if (lat !== k) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, k);
    end
    n_cmp++;
    if (bcnt !== k) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, bcnt, k);
    end
    n_cmp++;
    if (dcnt !== 1) begin
      n_err++;
      $display("FAIL %s done_pulses: got %0d want 1", name, dcnt);
    end
    n_cmp++;
    if (eq_o !== eq_m || idx_o !== idx_m) begin
      n_err++;
      $display("FAIL %s result: got eq=%b idx=%0d want eq=%b idx=%0d",
               name, eq_o, idx_o, eq_m, idx_m);
    end
    n_cmp++;
    if (!idle_ok) begin
      n_err++;
      $display("FAIL %s idle_after_done: busy=%b done=%b want 0 0", name, busy, done);
    end
    $display("run %s a=%h b=%h k=%0d lat=%0d eq=%b idx=%0d", name, av, bv, k, lat, eq_o, idx_o);
  endtask

  task automatic test_reset();
    start = 1'b1; a = 8'hFF; b = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, equal, diff_idx} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b eq=%b idx=%0d want all 0",
               busy, done, equal, diff_idx);
    end
    $display("reset busy=%b done=%b eq=%b idx=%0d", busy, done, equal, diff_idx);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    check_run("equal_a5", 8'hA5, 8'hA5, 1'b0, 1'b0);
    check_run("early_mis", 8'hA5, 8'hA4, 1'b0, 1'b0);
    check_run("last_bit", 8'h80, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_operand_change();
    check_run("mid_chg", 8'h10, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_ignored_start();
    check_run("hold_start", 8'h3C, 8'h3C, 1'b1, 1'b0);
    check_run("hold_start2", 8'h08, 8'h00, 1'b1, 1'b0);
    check_run("after_hold", 8'h80, 8'h00, 1'b0, 1'b0);
    a = 8'h12; b = 8'h34;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (equal !== 1'b0 || diff_idx !== 3'd7 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL hold_idle: got eq=%b idx=%0d busy=%b want eq=0 idx=7 busy=0",
               equal, diff_idx, busy);
    end
    $display("hold_idle eq=%b idx=%0d", equal, diff_idx);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 8'h5A; b = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, equal, diff_idx} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b done=%b eq=%b idx=%0d want all 0",
               busy, done, equal, diff_idx);
    end
    $display("reset_mid busy=%b done=%b eq=%b idx=%0d", busy, done, equal, diff_idx);
    @(negedge clk);
    rst_n = 1'b1;
    check_run("post_reset", 8'hC3, 8'hC3, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    for (int i = 0; i < 30; i++) begin
      av = W'($urandom);
      case ($urandom_range(0, 2))
        0: bv = av;
        1: bv = av ^ (W'(1) << $urandom_range(0, W - 1));
        default: bv = W'($urandom);
      endcase
      check_run("rand", av, bv, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_operand_change();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_word_equality.md
# serial_word_equality

Bit-serial multi-bit equality comparator for the Basys3 gate-design set. It captures two WIDTH-bit words on a start request and checks them one bit per clock, LSB first, through a single one-bit XNOR equality cell. It stops at the first mismatching bit and reports the result, the index of that bit, and a one-cycle done pulse. It sits directly downstream of the one-bit equality cell and turns that cell's per-bit result into a word-level verdict for the board's LEDs or for later logic.

## Interface
Parameters:
- WIDTH, 8: word width in bits; must be ≥ 2.
- IDX_W, $clog2(WIDTH): width of the mismatch index.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a comparison; acted on only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high while in COMPARE.
- done  output  1  one-cycle pulse; high only in DONE.
- equal  output  1  1 = words identical; valid from done, held until the next accepted start.
- diff_idx  output  IDX_W  index of the first (lowest) differing bit; 0 when equal.

## Operation
- States:
  - IDLE: wait for start.
  - COMPARE: examine one bit per cycle.
  - DONE: single cycle, done=1, then return to IDLE.
- IDLE and start=1 at an edge:
  - load shift registers sa←a and sb←b.
  - bit counter idx←0; clear equal to 0 and diff_idx to 0.
  - go to COMPARE.
- COMPARE, each cycle:
  - feed sa[0] and sb[0] into the XNOR cell, giving eq_bit.
  - eq_bit=0: at the edge, equal←0, diff_idx←idx, go to DONE.
  - eq_bit=1 and idx==WIDTH-1: at the edge, equal←1, diff_idx←0, go to DONE.
  - otherwise: shift sa and sb right by 1, idx←idx+1, stay in COMPARE.
- DONE: go to IDLE unconditionally. start in this cycle is ignored.
- start while in COMPARE or DONE is ignored. Changes on a or b after capture have no effect.
- idx never wraps, because COMPARE always exits at WIDTH-1.
- Reset at any point, including mid-COMPARE, has priority over everything else:
  - state←IDLE; sa, sb and idx←0.
  - busy, done and equal←0; diff_idx←0.

## Timing
- All outputs are registered or decoded from state only. No combinational path from a, b or start to any output.
- start accepted at edge T. Let k be the number of bits examined: k = first mismatch index + 1, or WIDTH when the words are equal.
- busy=1 from edge T to edge T+k.
- DONE entered at edge T+k:
  - done=1 for exactly one cycle;
  - equal and diff_idx are valid from T+k onward.
- Back in IDLE at edge T+k+1. The earliest next accepted start is at edge T+k+1.
- Maximum latency from start to done is WIDTH cycles; minimum is 1 cycle (mismatch at bit 0).
- Throughput: one comparison per k+1 cycles.

## Structure
- Shared package (serial_eq_pkg):
  - state encoding localparams ST_IDLE=2'd0, ST_COMPARE=2'd1, ST_DONE=2'd2;
  - nothing else.
- One sub-module: oneBitEquality, the existing one-bit XNOR equality cell, instantiated once. Its inputs are sa[0] and sb[0]; its output is eq_bit.
- Block contents:
  - FSM register with next-state logic;
  - two WIDTH-bit shift registers;
  - IDX_W-bit counter;
  - result registers for equal and diff_idx.

## Test plan
All scenarios use WIDTH=8.
- Equal words: a=0xA5, b=0xA5, start at T → busy high for 8 cycles; done at T+8; equal=1, diff_idx=0; IDLE at T+9.
- Early mismatch: a=0xA5, b=0xA4 → done at T+1; equal=0, diff_idx=0; busy high for 1 cycle.
- Last-bit mismatch: a=0x80, b=0x00 → done at T+8; equal=0, diff_idx=7.
- Mid mismatch with operand change: a=0x10, b=0x00 → done at T+5, equal=0, diff_idx=4.
  - Change a to 0x00 during COMPARE → result unchanged.
- Ignored starts:
  - start held high through COMPARE and DONE → no restart.
  - next run is accepted at T+k+1; done pulses exactly once per run.
  - results hold while idle.
- Reset mid-run: rst_n=0 at T+3 of an equal-word run → next edge gives state IDLE, busy=0, done=0, equal=0, diff_idx=0.
  - A new start after rst_n=1 completes normally.
